// File: rtl/uart_tx_queue_if.sv
// Bus bundle between the CPU-side writer / UART TX driver (master modport) and uart_tx_queue (slave modport).
// Handshake: trmt is the head-valid request; the driver pops by pulsing ack_trmt for one cycle while trmt=1,
// and reports end of shifting with a 1-cycle tx_done. wr_en is a fire-and-forget push; drops are visible on full/ovf.
interface uart_tx_queue_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          ack_trmt;
  logic          tx_done;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          tx_busy;
  logic          drained;
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output wr_en, wr_data, flush, ack_trmt, tx_done, ovf_clr,
    input  trmt, tx_data, full, empty, count, tx_busy, drained, ovf
  );

  modport slave (
    input  wr_en, wr_data, flush, ack_trmt, tx_done, ovf_clr,
    output trmt, tx_data, full, empty, count, tx_busy, drained, ovf
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmit driver, with in-flight tracking for a drained-line poll.
// Optional sticky overflow flag enabled by defining UART_TXQ_OVF_EN.
module uart_tx_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_queue_if.slave  bus
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          tx_busy_q, tx_busy_d;
  logic          ovf_q, ovf_d;

  logic          empty, full;
  logic          push, pop, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // Flush discards any concurrent push/pop; a pop frees a slot so a write to a full queue still lands.
  always_comb begin
    pop  = bus.ack_trmt & ~empty & ~bus.flush;
    push = bus.wr_en & (~full | pop) & ~bus.flush;
    drop = bus.wr_en & full & ~pop & ~bus.flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // A new byte entering the wire outranks the previous byte's completion.
  always_comb begin
    tx_busy_d = tx_busy_q;
    if (pop)              tx_busy_d = 1'b1;
    else if (bus.tx_done) tx_busy_d = 1'b0;
  end

`ifdef UART_TXQ_OVF_EN
  always_comb begin
    ovf_d = ovf_q;
    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = bus.ovf_clr | drop;
  always_comb ovf_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_busy_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_busy_q <= tx_busy_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage carries no reset; stale contents are never visible because tx_data is gated by empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.trmt    = ~empty;
  assign bus.tx_data = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.count   = count_q;
  assign bus.tx_busy = tx_busy_q;
  assign bus.drained = empty & ~tx_busy_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef UART_TXQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.AW(AW)) bus ();
  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: byte queue plus in-flight and overflow flags.
  logic [7:0] exp_q[$];
  bit m_busy = 1'b0;
  bit m_ovf  = 1'b0;

  always @(posedge clk) begin : model
    bit m_pop, m_push, m_drop;
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else if (bus.flush) begin
      exp_q.delete();
      if (bus.tx_done) m_busy = 1'b0;
      if (bus.ovf_clr) m_ovf = 1'b0;
    end else begin
      m_pop  = bus.ack_trmt && (exp_q.size() > 0);
      m_push = bus.wr_en && ((exp_q.size() < DEPTH) || m_pop);
      m_drop = bus.wr_en && !m_push;
      if (m_drop && OVF_EN) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_busy = 1'b1;
      end else if (bus.tx_done) begin
        m_busy = 1'b0;
      end
      if (m_push) exp_q.push_back(bus.wr_data);
    end
  end

  always @(negedge clk) begin : compare
    logic [17:0] act, exp;
    logic [7:0]  head;
    bit          e;
    if (chk_en) begin
      e    = (exp_q.size() == 0);
      head = 8'h00;
      if (!e) head = exp_q[0];
      exp = {~e, head, 4'(exp_q.size()), exp_q.size() == DEPTH, e, m_busy, e & ~m_busy, m_ovf};
      act = {bus.trmt, bus.tx_data, bus.count, bus.full, bus.empty, bus.tx_busy, bus.drained, bus.ovf};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t got=%h expected=%h (trmt,data,count,full,empty,busy,drained,ovf)",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus.flush    = 1'b0;
    bus.ack_trmt = 1'b0;
    bus.tx_done  = 1'b0;
    bus.ovf_clr  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic ack_once();
    bus.ack_trmt = 1'b1;
    tick();
    bus.ack_trmt = 1'b0;
  endtask

  task automatic done_once();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    chk_en = 1'b1;

    // Reset state and single byte round trip
    chk("rst_trmt", bus.trmt, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_drained", bus.drained, 1);
    chk("rst_count", bus.count, 0);
    push_byte(8'hA5);
    chk("t1_trmt", bus.trmt, 1);
    chk("t1_tx_data", bus.tx_data, 8'hA5);
    chk("t1_count", bus.count, 1);
    ack_once();
    chk("t1_empty", bus.empty, 1);
    chk("t1_busy", bus.tx_busy, 1);
    chk("t1_not_drained", bus.drained, 0);
    done_once();
    chk("t1_drained", bus.drained, 1);

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk("t2_full", bus.full, 1);
    chk("t2_count", bus.count, 8);
    push_byte(8'h09);
    chk("t2_count_after_drop", bus.count, 8);
    chk("t2_ovf", bus.ovf, 32'(OVF_EN));
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", bus.ovf, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_order", bus.tx_data, 32'(i));
      ack_once();
    end
    chk("t2_empty", bus.empty, 1);
    done_once();

    // Push+pop on a full queue keeps the write
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    bus.wr_en = 1'b1; bus.wr_data = 8'h55; bus.ack_trmt = 1'b1;
    tick();
    idle();
    chk("t3_count", bus.count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", bus.tx_data, (i < 7) ? 32'(8'h11 + 8'(i)) : 32'h55);
      ack_once();
    end
    done_once();

    // Wraparound at rate 1
    do_reset();
    for (int k = 0; k < 20; k++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'h20 + 8'(k);
      bus.ack_trmt = 1'b1; bus.tx_done = 1'b1;
      tick();
    end
    idle();
    chk("t4_count", bus.count, 1);
    chk("t4_last", bus.tx_data, 8'h33);
    chk("t4_busy", bus.tx_busy, 1);

    // Flush with a byte in flight
    do_reset();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    ack_once();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t5_count", bus.count, 0);
    chk("t5_trmt", bus.trmt, 0);
    chk("t5_busy", bus.tx_busy, 1);
    chk("t5_not_drained", bus.drained, 0);
    done_once();
    chk("t5_drained", bus.drained, 1);

    // tx_done coinciding with ack, then reset mid-queue
    do_reset();
    push_byte(8'hC1); push_byte(8'hC2);
    ack_once();
    bus.ack_trmt = 1'b1; bus.tx_done = 1'b1;
    tick();
    idle();
    chk("t6_busy_set_wins", bus.tx_busy, 1);
    chk("t6_count", bus.count, 0);
    push_byte(8'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_count", bus.count, 0);
    chk("t6_rst_busy", bus.tx_busy, 0);
    done_once();
    chk("t6_stray_done", bus.tx_busy, 0);
    chk("t6_drained", bus.drained, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.wr_en    = ($urandom_range(0, 99) < 55);
      bus.wr_data  = 8'($urandom_range(0, 255));
      bus.ack_trmt = ($urandom_range(0, 99) < 45);
      bus.tx_done  = ($urandom_range(0, 99) < 30);
      bus.flush    = ($urandom_range(0, 99) < 3);
      bus.ovf_clr  = ($urandom_range(0, 99) < 5);
      rst          = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle();
    rst = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
